// File: rtl/minilogix_pkg.sv
// Shared constants and per-cell configuration layout for the minilogix fabric.
package minilogix_pkg;

   localparam int NUM_CELLS  = 8;
   localparam int LUT_K      = 4;
   localparam int CELL_CFG_W = 33;
   localparam int CHAIN_W    = NUM_CELLS * CELL_CFG_W;

   localparam int LUT_LSB    = 0;
   localparam int SEL_LSB    = 16;
   localparam int SEL_W      = 4;
   localparam int REGEN_BIT  = 32;

   localparam int SRC_W      = 2 * NUM_CELLS;

   // Field order runs MSB to LSB, so the struct overlays a 33-bit chain slice directly.
   typedef struct packed {
      logic             reg_en;
      logic [SEL_W-1:0] sel3;
      logic [SEL_W-1:0] sel2;
      logic [SEL_W-1:0] sel1;
      logic [SEL_W-1:0] sel0;
      logic [15:0]      lut;
   } cell_cfg_t;

endpackage

// File: rtl/minilogix_cell.sv
// One fabric cell: four 16:1 source muxes feeding a 4-input LUT, plus its q register.
module minilogix_cell
   import minilogix_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             upd_en,
   input  cell_cfg_t        cfg,
   input  logic [SRC_W-1:0] src,
   output logic             f,
   output logic             q
);

   logic [LUT_K-1:0] lut_idx;

   assign lut_idx = {src[cfg.sel3], src[cfg.sel2], src[cfg.sel1], src[cfg.sel0]};
   assign f       = cfg.lut[lut_idx];

   // NOTE: sequential state uses non-blocking assignments so every cell samples
   // the same pre-edge q values when they read each other through the source bus.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         q <= 1'b0;
      end else if (upd_en) begin
         q <= f;
      end
   end

endmodule

// File: rtl/tt_um_hpretl_minilogix.sv
// Tiny Tapeout top: 264-bit config shift chain, eight LUT cells and output gating.
// Build option: define MINILOGIX_READBACK_EN to drive the chain MSB out on uio_out[4].
module tt_um_hpretl_minilogix
   import minilogix_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic                 cfg_en;
   logic                 cfg_data;
   logic                 upd_en;
   logic [CHAIN_W-1:0]   chain;
   logic [NUM_CELLS-1:0] f;
   logic [NUM_CELLS-1:0] q;
   logic [NUM_CELLS-1:0] reg_en;
   logic [SRC_W-1:0]     src;
   logic                 unused_uio;

   assign cfg_en     = uio_in[0];
   assign cfg_data   = uio_in[1];
   assign unused_uio = &{1'b0, uio_in[7:2]};

   // Shifting and evaluation are mutually exclusive, so q is frozen during a load.
   assign upd_en = ena & ~cfg_en;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         chain <= '0;
      end else if (ena && cfg_en) begin
         chain <= {chain[CHAIN_W-2:0], cfg_data};
      end
   end

   // Cells only ever see registered outputs of other cells, never f, so no loops exist.
   assign src = {q, ui_in};

   for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
      cell_cfg_t cfg;

      assign cfg       = chain[k*CELL_CFG_W +: CELL_CFG_W];
      assign reg_en[k] = cfg.reg_en;

      minilogix_cell u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .upd_en (upd_en),
         .cfg    (cfg),
         .src    (src),
         .f      (f[k]),
         .q      (q[k])
      );
   end

   // NOTE: combinational outputs get a default first so no path can infer a latch.
   always_comb begin
      uo_out = '0;
      if (!cfg_en) begin
         uo_out = (reg_en & q) | (~reg_en & f);
      end
   end

`ifdef MINILOGIX_READBACK_EN
   assign uio_oe  = 8'h10;
   assign uio_out = {3'b000, chain[CHAIN_W-1], 4'b0000};
`else
   assign uio_oe  = 8'h00;
   assign uio_out = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_hpretl_minilogix.sv
// Self-checking bench for tt_um_hpretl_minilogix against a behavioural fabric model.
// Readback checks are active when MINILOGIX_READBACK_EN is defined.
module tb_tt_um_hpretl_minilogix;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       cfg_en;
   logic       cfg_data;
   logic [5:0] junk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: the chain as a flat bit vector and the eight cell registers.
   logic [263:0] m_chain;
   logic [7:0]   m_q;

   assign uio_in = {junk, cfg_data, cfg_en};

   tt_um_hpretl_minilogix dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [32:0] mk_cell(input int lut, input int s0, input int s1,
                                           input int s2, input int s3, input int regen);
      logic [32:0] c;
      c = 33'(lut & 16'hffff);
      c = c | (33'(s0 & 15) << 16) | (33'(s1 & 15) << 20) | (33'(s2 & 15) << 24)
            | (33'(s3 & 15) << 28) | (33'(regen & 1) << 32);
      return c;
   endfunction

   function automatic logic model_f(input int k);
      logic [32:0] c;
      int          idx;
      int          s;
      logic        b;
      c   = m_chain[k*33 +: 33];
      idx = 0;
      for (int n = 0; n < 4; n++) begin
         s = int'((c >> (16 + 4*n)) & 33'd15);
         b = (s < 8) ? ui_in[s] : m_q[s-8];
         if (b) idx = idx + (1 << n);
      end
      return c[idx];
   endfunction

   function automatic logic [7:0] exp_uo();
      logic [7:0]  o;
      logic [32:0] c;
      o = 8'h00;
      if (!cfg_en) begin
         for (int k = 0; k < 8; k++) begin
            c    = m_chain[k*33 +: 33];
            o[k] = c[32] ? m_q[k] : model_f(k);
         end
      end
      return o;
   endfunction

   function automatic logic [7:0] exp_uio_out();
`ifdef MINILOGIX_READBACK_EN
      return m_chain[263] ? 8'h10 : 8'h00;
`else
      return 8'h00;
`endif
   endfunction

   function automatic logic [7:0] exp_uio_oe();
`ifdef MINILOGIX_READBACK_EN
      return 8'h10;
`else
      return 8'h00;
`endif
   endfunction

   function automatic void model_step();
      logic [7:0] nq;
      if (rst_n) begin
         m_chain = '0;
         m_q     = '0;
      end else if (ena) begin
         if (cfg_en) begin
            m_chain = {m_chain[262:0], cfg_data};
         end else begin
            for (int k = 0; k < 8; k++) nq[k] = model_f(k);
            m_q = nq;
         end
      end
   endfunction

   // Advance one clock: model consumes the pre-edge inputs, then the DUT edge occurs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      junk = 6'($urandom);
   endtask

   task automatic shift_in(input logic [263:0] v);
      for (int i = 263; i >= 0; i--) begin
         ena      = 1'b1;
         cfg_en   = 1'b1;
         cfg_data = v[i];
         tick();
      end
      cfg_en   = 1'b0;
      cfg_data = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ena      = 1'($urandom);
         cfg_en   = 1'($urandom);
         cfg_data = 1'($urandom);
         ui_in    = 8'($urandom);
         tick();
      end
      rst_n  = 1'b0;
      ena    = 1'b1;
      cfg_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ui_in = 8'($urandom);
         #1;
         n_vec++;
         if (uo_out !== 8'h00) begin
            $display("FAIL reset_uo_out: got %h want 00", uo_out);
            n_err++;
         end
         n_vec++;
         if (uio_oe !== exp_uio_oe()) begin
            $display("FAIL reset_uio_oe: got %h want %h", uio_oe, exp_uio_oe());
            n_err++;
         end
         n_vec++;
         if (uio_out !== 8'h00) begin
            $display("FAIL reset_uio_out: got %h want 00", uio_out);
            n_err++;
         end
         tick();
      end
   endtask

   task automatic test_and_gate();
      logic [263:0] v;
      logic [7:0]   pats [3] = '{8'h03, 8'h01, 8'h02};
      logic         want [3] = '{1'b1, 1'b0, 1'b0};
      v = '0;
      v[32:0] = mk_cell(16'h8888, 0, 1, 0, 0, 0);
      shift_in(v);
      for (int i = 0; i < 3; i++) begin
         ui_in = pats[i];
         #1;
         n_vec++;
         if (uo_out[0] !== want[i]) begin
            $display("FAIL and_gate ui=%h: got %b want %b", ui_in, uo_out[0], want[i]);
            n_err++;
         end
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         ui_in = 8'($urandom);
         #1;
         n_vec++;
         if (uo_out !== exp_uo()) begin
            $display("FAIL and_gate_rand ui=%h: got %h want %h", ui_in, uo_out, exp_uo());
            n_err++;
         end
         tick();
      end
   endtask

   task automatic test_toggle_holds();
      logic [263:0] v;
      logic         held;
      v = '0;
      v[65:33] = mk_cell(16'h5555, 9, 0, 0, 0, 1);
      shift_in(v);
      for (int i = 0; i < 4; i++) begin
         ui_in = 8'($urandom);
         tick();
         n_vec++;
         if (uo_out[1] !== ((i % 2) == 0) || uo_out !== exp_uo()) begin
            $display("FAIL toggle step %0d: got %h want bit1=%b model %h", i, uo_out,
                     (i % 2) == 0, exp_uo());
            n_err++;
         end
      end
      held = uo_out[1];
      ena  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ui_in = 8'($urandom);
         tick();
         n_vec++;
         if (uo_out[1] !== held) begin
            $display("FAIL ena_hold %0d: got %b want %b", i, uo_out[1], held);
            n_err++;
         end
      end
      // Reload the same image so the chain survives the cfg_en window unchanged.
      for (int i = 263; i >= 0; i--) begin
         ena      = 1'b1;
         cfg_en   = 1'b1;
         cfg_data = v[i];
         #1;
         if (i % 66 == 0) begin
            n_vec++;
            if (uo_out !== 8'h00) begin
               $display("FAIL cfg_gate: got %h want 00", uo_out);
               n_err++;
            end
         end
         tick();
      end
      cfg_en = 1'b0;
      #1;
      n_vec++;
      if (uo_out[1] !== held) begin
         $display("FAIL cfg_hold: got %b want %b", uo_out[1], held);
         n_err++;
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (uo_out[1] !== (held ^ ((i % 2) == 0))) begin
            $display("FAIL toggle_resume %0d: got %b want %b", i, uo_out[1],
                     held ^ ((i % 2) == 0));
            n_err++;
         end
      end
   endtask

   task automatic test_readback();
      logic [263:0] v;
      for (int i = 0; i < 264; i++) v[263-i] = (i % 3 == 0);
      shift_in(v);
      for (int j = 0; j < 264; j++) begin
         ena      = 1'b1;
         cfg_en   = 1'b1;
         cfg_data = 1'b0;
         #1;
`ifdef MINILOGIX_READBACK_EN
         n_vec++;
         if (uio_out[4] !== (j % 3 == 0)) begin
            $display("FAIL readback bit %0d: got %b want %b", j, uio_out[4], j % 3 == 0);
            n_err++;
         end
`endif
         n_vec++;
         if (uio_out !== exp_uio_out() || uio_oe !== exp_uio_oe()) begin
            $display("FAIL readback_bus %0d: got %h/%h want %h/%h", j, uio_out, uio_oe,
                     exp_uio_out(), exp_uio_oe());
            n_err++;
         end
         tick();
      end
      cfg_en = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 100; i++) begin
         ena      = 1'b1;
         cfg_en   = 1'b1;
         cfg_data = 1'b1;
         tick();
      end
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      for (int j = 0; j < 264; j++) begin
         cfg_data = 1'b0;
         #1;
         n_vec++;
         if (uio_out !== 8'h00) begin
            $display("FAIL midload_readback %0d: got %h want 00", j, uio_out);
            n_err++;
         end
         tick();
      end
      cfg_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ui_in = 8'($urandom);
         #1;
         n_vec++;
         if (uo_out !== 8'h00) begin
            $display("FAIL midload_uo_out: got %h want 00", uo_out);
            n_err++;
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [263:0] v;
      for (int r = 0; r < 5; r++) begin
         for (int b = 0; b < 264; b++) v[b] = 1'($urandom);
         shift_in(v);
         for (int i = 0; i < 60; i++) begin
            ena      = ($urandom % 8) != 0;
            cfg_en   = ($urandom % 16) == 0;
            cfg_data = 1'($urandom);
            ui_in    = 8'($urandom);
            #1;
            n_vec++;
            if (uo_out !== exp_uo() || uio_out !== exp_uio_out() || uio_oe !== exp_uio_oe()) begin
               $display("FAIL random r%0d c%0d: got uo=%h uio=%h oe=%h want %h %h %h", r, i,
                        uo_out, uio_out, uio_oe, exp_uo(), exp_uio_out(), exp_uio_oe());
               n_err++;
            end
            tick();
         end
      end
      cfg_en = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b1;
      ena      = 1'b0;
      ui_in    = 8'h00;
      cfg_en   = 1'b0;
      cfg_data = 1'b0;
      junk     = 6'h00;
      m_chain  = '0;
      m_q      = '0;
      test_reset();
      test_and_gate();
      test_toggle_holds();
      test_readback();
      test_reset_mid_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tt_um_hpretl_minilogix.md
Name: tt_um_hpretl_minilogix

Overview:
Tiny Tapeout user macro implementing a miniature programmable logic fabric.
- Eight 4-input LUT cells, each with a selectable output flip-flop.
- Cell inputs are routed from ui_in and from the cell registers through per-input 16:1 muxes.
- Configuration is loaded serially through a 264-bit shift chain driven from uio_in.
- Sits directly under the TT harness as the top-level user project.

Parameters:
- NUM_CELLS, 8, number of LUT cells; fixed by the uo_out width.
- LUT_K, 4, LUT inputs per cell.
- CELL_CFG_W, 33, config bits per cell (16 LUT + 4x4 select + 1 reg_en).
- CHAIN_W, 264, total config chain length (NUM_CELLS*CELL_CFG_W).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  reset, synchronous and active-high. The name is kept from the harness; 1 = reset asserted.
- ena  input  1  design enable; when 0 all state holds.
- ui_in  input  8  fabric logic inputs (sources 0..7).
- uo_out  output  8  cell outputs, bit k = cell k.
- uio_in  input  8  bit0 = cfg_en, bit1 = cfg_data, bits 7:2 unused.
- uio_out  output  8  bit4 = cfg_out (readback); all other bits 0.
- uio_oe  output  8  output enables; see Optional Feature.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst_n=1 at a clk edge): config chain := 0, all cell regs q := 0. Reset overrides ena and cfg_en. Reset mid-configuration discards the partial load.
- Chain fields:
  - Cell k owns chain[33k+32:33k].
  - [15:0] lut, [19:16] sel0, [23:20] sel1, [27:24] sel2, [31:28] sel3, [32] reg_en.
- Shift: when ena=1 and cfg_en=1, each clk does chain <= {chain[262:0], cfg_data}. Load MSB-first: the first bit shifted becomes chain[263] (cell7 reg_en) after 264 shifts.
- Source index s (4 bit): 0..7 = ui_in[s]; 8..15 = q[s-8]. Sources are never combinational cell outputs, so no combinational loops are possible.
- LUT evaluation: f[k] = lut[{in3,in2,in1,in0}], where inN = source(selN).
- Register update: when ena=1 and cfg_en=0, q[k] <= f[k] every clk for all cells, regardless of reg_en.
  - cfg_en=1 freezes q.
  - ena=0 freezes q and the chain.
- Output: uo_out[k] = cfg_en ? 0 : (reg_en[k] ? q[k] : f[k]).
  - Combinational cells have zero latency from ui_in.
  - Registered cells have one cycle of latency.
- After reset: uo_out = 0x00 (all LUTs are zero).
- uio_out[7:5] and [3:0] are always 0.

Optional Feature:
- Macro MINILOGIX_READBACK_EN.
- Defined: uio_oe = 8'h10 and uio_out[4] = chain[263] (registered chain MSB). Allows chain verification by shifting out.
- Undefined: uio_oe = 8'h00 and uio_out = 8'h00; the readback path is removed.

Decomposition:
- Package minilogix_pkg holds:
  - constants NUM_CELLS, LUT_K, CELL_CFG_W, CHAIN_W;
  - field offsets LUT_LSB=0, SEL_LSB=16, SEL_W=4, REGEN_BIT=32;
  - a cell_cfg_t packed struct matching the field layout.
- Sub-module minilogix_cell, instantiated 8x. Per cell:
  - Inputs: 33-bit cfg slice, the 16-bit source bus, and clk/rst_n/update enable.
  - Outputs: f and q.
  - Contents: source muxes, LUT, q register.
- The top level holds the shift chain and the output gating.

Test Plan:
- Reset: rst_n=1 for 2 clk, then rst_n=0 with any ui_in. Expect uo_out=0x00, and uio_oe=0x10 with readback (0x00 without).
- AND gate in cell0:
  - Config: lut=0x8888, sel0=0, sel1=1, sel2=sel3=0, reg_en=0; all other cells 0.
  - ui_in=0x03 gives uo_out[0]=1 in the same cycle; ui_in=0x01 gives 0; ui_in=0x02 gives 0.
- Toggle in cell1: lut=0x5555, sel0=9, reg_en=1. After cfg_en drops, uo_out[1] sequence is 1,0,1,0 on successive clk.
- Holds during toggle:
  - ena=0 for 3 clk: uo_out[1] frozen.
  - cfg_en=1 (with ena=1): uo_out=0x00 and q frozen. Toggling resumes from the frozen q once cfg_en returns to 0.
- Readback (macro on): shift in 264 bits with pattern bit i=(i%3==0), then 264 zeros. uio_out[4] reproduces the pattern in order, starting on the first zero-shift cycle.
- Reset mid-load: shift 100 bits of 1s, assert rst_n=1 for 1 clk. Readback gives 264 zeros and uo_out=0x00.
